// File: rtl/contador_regressivo_bcd.sv
// rtl/contador_regressivo_bcd.sv - multi-digit BCD countdown timer, optional auto-reload via CONTADOR_REGRESSIVO_RELOAD_EN
module contador_regressivo_bcd #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  output logic [4*DIGITS-1:0] count,
  output logic                zero,
  output logic                done,
  output logic                running
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [W-1:0]   r_count, w_count_nxt;
  logic [W-1:0]   w_clamped;
  logic [W-1:0]   w_dec;
  logic           r_done, w_done_nxt;
`ifdef CONTADOR_REGRESSIVO_RELOAD_EN
  logic [W-1:0]   r_reload, w_reload_nxt;
`endif

  // Clamp every preset nibble to a legal BCD digit (A-F saturate at 9)
  always_comb begin
    w_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_clamped[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
    end
  end

  // BCD decrement: zero digits wrap to 9 and pass the borrow upward
  always_comb begin
    logic v_borrow;
    w_dec    = r_count;
    v_borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v_borrow) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          v_borrow        = 1'b0;
        end
      end
    end
  end

  // Next-state logic: load wins over enable; expiry raises done for one edge
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_done_nxt   = 1'b0;
`ifdef CONTADOR_REGRESSIVO_RELOAD_EN
    w_reload_nxt = r_reload;
`endif
    if (load) begin
      w_count_nxt  = w_clamped;
`ifdef CONTADOR_REGRESSIVO_RELOAD_EN
      w_reload_nxt = w_clamped;
`endif
      w_state_nxt  = (w_clamped != '0) ? S_RUN : S_EXPIRED;
    end else begin
      case (r_state)
        S_RUN: begin
          if (enable) begin
            w_count_nxt = w_dec;
            if (w_dec == '0) begin
              w_state_nxt = S_EXPIRED;
              w_done_nxt  = 1'b1;
            end
          end
        end
        S_EXPIRED: begin
`ifdef CONTADOR_REGRESSIVO_RELOAD_EN
          // A zero reload value leaves the timer parked in EXPIRED
          if (enable && (r_reload != '0)) begin
            w_count_nxt = r_reload;
            w_state_nxt = S_RUN;
          end
`else
          w_count_nxt = r_count;
`endif
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // State, count and pulse registers with immediate asynchronous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_done   <= 1'b0;
`ifdef CONTADOR_REGRESSIVO_RELOAD_EN
      r_reload <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_done   <= w_done_nxt;
`ifdef CONTADOR_REGRESSIVO_RELOAD_EN
      r_reload <= w_reload_nxt;
`endif
    end
  end

  assign count   = r_count;
  assign zero    = (r_count == '0);
  assign done    = r_done;
  assign running = (r_state == S_RUN);

endmodule

// File: tb/tb_contador_regressivo_bcd.sv
// tb/tb_contador_regressivo_bcd.sv - randomized self-checking bench for contador_regressivo_bcd
module tb_contador_regressivo_bcd;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       load;
  logic [7:0] load_value;
  logic [7:0] count;
  logic       zero;
  logic       done;
  logic       running;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: count kept as a plain integer 0..99
  int m_val;
  int m_reload;
  int m_mode;   // 0 idle, 1 counting, 2 expired
  bit m_done;

  contador_regressivo_bcd #(.DIGITS(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .zero       (zero),
    .done       (done),
    .running    (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'((v / 10) % 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic int preset_value(input logic [7:0] lv);
    int hi;
    int lo;
    hi = int'(lv[7:4]);
    lo = int'(lv[3:0]);
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    return hi * 10 + lo;
  endfunction

  task automatic model_reset();
    m_val    = 0;
    m_reload = 0;
    m_mode   = 0;
    m_done   = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit ld, input logic [7:0] lv);
    m_done = 1'b0;
    if (ld) begin
      m_val    = preset_value(lv);
      m_reload = m_val;
      m_mode   = (m_val != 0) ? 1 : 2;
    end else if (m_mode == 1 && en) begin
      m_val = m_val - 1;
      if (m_val == 0) begin
        m_mode = 2;
        m_done = 1'b1;
      end
    end else if (m_mode == 2 && en) begin
`ifdef CONTADOR_REGRESSIVO_RELOAD_EN
      if (m_reload != 0) begin
        m_val  = m_reload;
        m_mode = 1;
      end
`endif
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},   32'(count),   32'(to_bcd(m_val)));
    check({tag, ".zero"},    32'(zero),    32'(m_val == 0));
    check({tag, ".done"},    32'(done),    32'(m_done));
    check({tag, ".running"}, 32'(running), 32'(m_mode == 1));
  endtask

  // Called at a falling edge; drives, lets one rising edge pass, checks #1 later
  task automatic tick(input string tag, input bit en, input bit ld, input logic [7:0] lv);
    enable     = en;
    load       = ld;
    load_value = lv;
    model_step(en, ld, lv);
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  // Pulse reset between edges and verify the clear is immediate
  task automatic async_reset(input string tag);
    #1 reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1 reset = 1'b1;
    @(negedge clk);
  endtask

  int done_cnt;
  bit gaps [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    reset      = 1'b0;
    enable     = 1'b0;
    load       = 1'b0;
    load_value = 8'h00;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 3; i++) tick("idle_en", 1'b1, 1'b0, 8'h00);

    tick("load12", 1'b0, 1'b1, 8'h12);
    for (int i = 0; i < 12; i++) tick("countdown", 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++)  tick("post_expiry", 1'b1, 1'b0, 8'h00);

`ifdef CONTADOR_REGRESSIVO_RELOAD_EN
    tick("reload_load12", 1'b0, 1'b1, 8'h12);
    done_cnt = 0;
    for (int i = 0; i < 26; i++) begin
      tick("reload_period", 1'b1, 1'b0, 8'h00);
      if (done) done_cnt++;
    end
    check("reload_done_count", 32'(done_cnt), 32'd2);
`endif

    tick("load3C", 1'b0, 1'b1, 8'h3C);
    check("clamp_3C", 32'(count), 32'h39);
    tick("load_prio", 1'b1, 1'b1, 8'h05);
    check("load_prio_05", 32'(count), 32'h05);
    tick("load00", 1'b1, 1'b1, 8'h00);
    tick("after00", 1'b0, 1'b0, 8'h00);

    tick("load20", 1'b0, 1'b1, 8'h20);
    for (int i = 0; i < 5; i++) tick("to15", 1'b1, 1'b0, 8'h00);
    check("reached_15", 32'(count), 32'h15);
    async_reset("async_rst");
    for (int i = 0; i < 3; i++) tick("idle_after_rst", 1'b1, 1'b0, 8'h00);

    tick("load03", 1'b0, 1'b1, 8'h03);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick("gaps", gaps[i], 1'b0, 8'h00);
      if (done) done_cnt++;
    end
    check("gaps_final", 32'(count), 32'h00);
    check("gaps_done_count", 32'(done_cnt), 32'd1);

    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        async_reset("rand_rst");
      end else if (r < 10) begin
        tick("rand_load", 1'($urandom_range(0, 1)), 1'b1, 8'($urandom));
      end else if (r < 16) begin
        tick("rand_small", 1'b0, 1'b1, 8'($urandom_range(0, 3)));
      end else begin
        tick("rand_run", 1'($urandom_range(0, 3) != 0), 1'b0, 8'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/contador_regressivo_bcd.md
Name: contador_regressivo_bcd

Overview:
Multi-digit BCD down-counter (countdown timer). It is the decrementing counterpart of the mod-10 up-counter.
- Loaded with a BCD value, then counts down to 00…0 on enabled clock edges.
- Digits borrow in cascade, 0→9.
- Flags expiry with a one-cycle done pulse.
- Used as a preset timer in front of the display / control logic.

Parameters:
DIGITS, 2, number of cascaded BCD digits; count width = 4*DIGITS.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset (reset=0 clears the block)
enable  input  1  decrement request, sampled on rising clk
load  input  1  synchronous load strobe
load_value  input  4*DIGITS  BCD preset, digit 0 in bits [3:0]
count  output  4*DIGITS  current BCD count
zero  output  1  count == 0 (combinational from count register)
done  output  1  registered one-cycle expiry pulse
running  output  1  high while state == RUN

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-count):
  - state=IDLE, count=0, done=0, running=0, zero=1.
  - Internal reload register = 0.
  - Effect is immediate, not at the next clock edge.
- States:
  - IDLE: after reset. Holds count; ignores enable.
  - RUN: decrementing.
  - EXPIRED: count has reached 0.
- Load (any state, rising edge with load=1):
  - Each loaded digit = min(load_value digit, 9). Non-BCD nibbles A–F clamp to 9.
  - Clamped value is written to count and to the reload register.
  - Next state = RUN if clamped value ≠ 0, else EXPIRED.
  - No done pulse on load.
  - load has priority over enable in the same cycle; no decrement occurs that cycle.
- Decrement (state=RUN, enable=1, load=0):
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - The top digit never underflows, because RUN implies count ≠ 0.
  - Latency: count updates on the same edge enable is sampled.
- Expiry:
  - The edge that writes count=0 from RUN sets state=EXPIRED and done=1.
  - done falls on the next edge.
  - done is high for exactly one cycle per expiry.
- RUN with enable=0: count holds, done=0.
- EXPIRED (feature off): count held at 0; enable ignored; no wrap to 99…9.
- running=1 iff state=RUN. zero is valid in every state.
- count is always valid BCD (every digit 0–9) in every reachable state.

Optional Feature:
Macro CONTADOR_REGRESSIVO_RELOAD_EN.
- Defined (periodic / auto-reload mode):
  - In EXPIRED, an edge with enable=1 and load=0 rewrites count from the reload register and returns to RUN.
  - If the reload register = 0, the block stays in EXPIRED with no further done pulses.
  - Resulting period is (value+1) enabled cycles, one done pulse per period.
- Not defined: EXPIRED is terminal until the next load or reset. The reload register may be optimised away.

Test Plan:
1. Reset, with DIGITS=2:
   - reset=0 → count=8'h00, zero=1, done=0, running=0.
   - Release reset, enable=1 for 3 cycles → count stays 8'h00 (IDLE).
2. Basic countdown:
   - load 8'h12, then enable=1 for 12 cycles.
   - count sequence 12,11,10,09,…,01,00; borrow visible at 10→09.
   - done=1 only on the cycle count becomes 00; running falls on that same edge.
3. Load handling:
   - load=1 with load_value=8'h3C → count=8'h39.
   - load=1 and enable=1 in the same cycle with 8'h05 → count=8'h05, no decrement.
   - Load 8'h00 → EXPIRED, done stays 0.
4. Post-expiry, after case 2, enable held 5 cycles:
   - Without the macro → count=00, done=0 throughout.
   - With CONTADOR_REGRESSIVO_RELOAD_EN → count returns to 12 on the first enabled edge, and a second done pulse arrives 13 enabled cycles after the first.
5. Asynchronous reset mid-count:
   - Load 8'h20, enable until count=8'h15, pulse reset=0 between clock edges.
   - count=8'h00 immediately; done=0; later enables are ignored (IDLE).
6. Enable gaps:
   - load 8'h03, enable pattern 1,0,0,1,0,1.
   - count 02,02,02,01,01,00; exactly one done pulse.
